// File: rtl/bsg_mask_merge_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bsg_mask_merge_accum                                          |
// | Description : Frame-based bit-masked merge accumulator. Beats are merged    |
// |               under a per-bit mask until a last beat, after which the word  |
// |               is held until the consumer takes it with yumi_i.             |
// | Option      : BSG_MASK_MERGE_WRITTEN_MASK_EN adds written_o, the OR of all  |
// |               masks accepted in the current frame.                          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module bsg_mask_merge_accum #(
    parameter int width_p          = 64,
    parameter int clear_on_start_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] mask_i,
    input  logic               last_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
`ifdef BSG_MASK_MERGE_WRITTEN_MASK_EN
    output logic [width_p-1:0] written_o,
`endif
    input  logic               yumi_i,
    output logic [7:0]         count_o
);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [width_p-1:0] acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic               ready_q, ready_d;
    logic               v_q, v_d;

    logic w_accept;
    logic w_take;

    // Beats are only seen in ACCUM and yumi only in FULL, so the two never coincide.
    assign w_accept = v_i    && (state_q == S_ACCUM);
    assign w_take   = yumi_i && (state_q == S_FULL);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ready_d = ready_q;
        v_d     = v_q;
        if (w_accept) begin
            acc_d = (data_i & mask_i) | (acc_q & ~mask_i);
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
            if (last_i) begin
                state_d = S_FULL;
                ready_d = 1'b0;
                v_d     = 1'b1;
            end
        end else if (w_take) begin
            state_d = S_ACCUM;
            ready_d = 1'b1;
            v_d     = 1'b0;
            count_d = 8'd0;
            if (clear_on_start_p != 0) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            count_q <= 8'd0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ready_q <= ready_d;
            v_q     <= v_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = acc_q;
    assign count_o = count_q;

`ifdef BSG_MASK_MERGE_WRITTEN_MASK_EN
    logic [width_p-1:0] written_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            written_q <= '0;
        end else if (w_accept) begin
            written_q <= written_q | mask_i;
        end else if (w_take) begin
            written_q <= '0;
        end
    end

    assign written_o = written_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i && yumi_i && (state_q == S_ACCUM)) begin
            $warning("bsg_mask_merge_accum: yumi_i asserted while v_o=0; ignored");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mask_merge_accum.sv
`default_nettype none
// Testbench for bsg_mask_merge_accum: directed scenarios plus random traffic
// checked against a frame-level reference model (clear and no-clear variants).
module tb_bsg_mask_merge_accum;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         v_i;
    logic [W-1:0] data_i;
    logic [W-1:0] mask_i;
    logic         last_i;
    logic         yumi_i;

    logic         ready0, v0, ready1, v1;
    logic [W-1:0] data0, data1;
    logic [7:0]   cnt0, cnt1;
`ifdef BSG_MASK_MERGE_WRITTEN_MASK_EN
    logic [W-1:0] wr0, wr1;
`endif

    bsg_mask_merge_accum #(.width_p(W), .clear_on_start_p(1)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i),
        .mask_i(mask_i), .last_i(last_i), .ready_o(ready0), .v_o(v0),
        .data_o(data0),
`ifdef BSG_MASK_MERGE_WRITTEN_MASK_EN
        .written_o(wr0),
`endif
        .yumi_i(yumi_i), .count_o(cnt0)
    );

    bsg_mask_merge_accum #(.width_p(W), .clear_on_start_p(0)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i),
        .mask_i(mask_i), .last_i(last_i), .ready_o(ready1), .v_o(v1),
        .data_o(data1),
`ifdef BSG_MASK_MERGE_WRITTEN_MASK_EN
        .written_o(wr1),
`endif
        .yumi_i(yumi_i), .count_o(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one frame-level view shared by both instances;
    // m_acc[0] restarts at zero, m_acc[1] keeps the previous word.
    bit           m_full;
    logic [W-1:0] m_acc [2];
    int           m_cnt;
    logic [W-1:0] m_wr;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full   = 1'b0;
        m_acc[0] = '0;
        m_acc[1] = '0;
        m_cnt    = 0;
        m_wr     = '0;
    endtask

    task automatic model_edge();
        if (!m_full) begin
            if (v_i) begin
                for (int k = 0; k < 2; k++) begin
                    for (int b = 0; b < W; b++) begin
                        if (mask_i[b]) m_acc[k][b] = data_i[b];
                    end
                end
                m_wr  = m_wr | mask_i;
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                if (last_i) m_full = 1'b1;
            end
        end else if (yumi_i) begin
            m_full   = 1'b0;
            m_cnt    = 0;
            m_acc[0] = '0;
            m_wr     = '0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready0"}, W'(ready0), W'(!m_full));
        chk({tag, ".v0"},     W'(v0),     W'(m_full));
        chk({tag, ".data0"},  data0,      m_acc[0]);
        chk({tag, ".count0"}, W'(cnt0),   W'(m_cnt));
        chk({tag, ".ready1"}, W'(ready1), W'(!m_full));
        chk({tag, ".v1"},     W'(v1),     W'(m_full));
        chk({tag, ".data1"},  data1,      m_acc[1]);
        chk({tag, ".count1"}, W'(cnt1),   W'(m_cnt));
`ifdef BSG_MASK_MERGE_WRITTEN_MASK_EN
        chk({tag, ".wr0"}, wr0, m_wr);
        chk({tag, ".wr1"}, wr1, m_wr);
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [W-1:0] m,
                         input logic l, input logic y, input string tag);
        v_i    = v;
        data_i = d;
        mask_i = m;
        last_i = l;
        yumi_i = y;
        step(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        v_i    = 1'b0;
        data_i = '0;
        mask_i = '0;
        last_i = 1'b0;
        yumi_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two-beat frame
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 0, 0, "two_beat_b0");
        drive(1, 64'h0, 64'h0F, 1, 0, "two_beat_b1");
        chk("two_beat.data", data0, 64'hF0);
        chk("two_beat.count", W'(cnt0), 64'd2);
        chk("two_beat.v", W'(v0), 64'd1);
        drive(0, 0, 0, 0, 1, "two_beat_yumi");

        // Single last beat with empty mask
        drive(1, 64'h1234, 64'h0, 1, 0, "mask0_last");
        chk("mask0.data", data0, 64'h0);
        chk("mask0.count", W'(cnt0), 64'd1);
        drive(0, 0, 0, 0, 1, "mask0_yumi");
        chk("mask0.ready_after_yumi", W'(ready0), 64'd1);
        chk("mask0.count_after_yumi", W'(cnt0), 64'd0);

        // Carry-over of the previous word when clear_on_start_p=0
        drive(1, 64'hAA, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "carry_f1");
        chk("carry.f1", data1, 64'hAA);
        drive(0, 0, 0, 0, 1, "carry_yumi1");
        drive(1, 64'h0, 64'h0F, 1, 0, "carry_f2");
        chk("carry.f2", data1, 64'hA0);
        chk("carry.f2_clear", data0, 64'h0);
        drive(0, 0, 0, 0, 1, "carry_yumi2");

        // Inputs ignored while FULL, yumi ignored while ACCUM
        drive(1, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "hold_fill");
        for (int i = 0; i < 5; i++) begin
            drive(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0, "hold_full");
        end
        chk("hold.data", data0, 64'h1234);
        chk("hold.count", W'(cnt0), 64'd1);
        drive(0, 0, 0, 0, 1, "hold_yumi");
        drive(0, 0, 0, 0, 1, "yumi_in_accum");
        chk("yumi_accum.ready", W'(ready0), 64'd1);
        chk("yumi_accum.v", W'(v0), 64'd0);

        // Count saturation
        for (int i = 0; i < 300; i++) begin
            drive(1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, "sat_beat");
        end
        drive(1, 64'h0, 64'h0, 1, 0, "sat_last");
        chk("sat.count", W'(cnt0), 64'd255);
        chk("sat.v", W'(v0), 64'd1);
        drive(0, 0, 0, 0, 1, "sat_yumi");

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) begin
            drive(1, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "rst_beat");
        end
        v_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset.data", data0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, "post_reset");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 3) == 0), m_full ? 1'($urandom_range(0, 1)) : 1'b0,
                  "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_mask_merge_accum.md
BSG_MASK_MERGE_ACCUM -- requirements
Module: bsg_mask_merge_accum

Interface
REQ-001 SHALL have parameter width_p, default 64, data and mask width in bits.
REQ-002 SHALL have parameter clear_on_start_p, default 1; 1 = the accumulator restarts from zero each frame, 0 = it restarts from the last emitted word.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port v_i  input  1  input beat valid.
REQ-006 SHALL have port data_i  input  width_p  beat data.
REQ-007 SHALL have port mask_i  input  width_p  per-bit select; 1 = take data_i bit, 0 = keep accumulator bit.
REQ-008 SHALL have port last_i  input  1  final beat of frame, qualified by v_i.
REQ-009 SHALL have port ready_o  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port v_o  output  1  merged word valid.
REQ-011 SHALL have port data_o  output  width_p  merged word.
REQ-012 SHALL have port yumi_i  input  1  consumer takes data_o; legal only while v_o=1.
REQ-013 SHALL have port count_o  output  8  beats accepted in the current frame, saturating.

Function
REQ-014 SHALL implement a two-state FSM, ACCUM and FULL; ACCUM: ready_o=1, v_o=0; FULL: ready_o=0, v_o=1.
REQ-015 SHALL accept a beat when v_i&ready_o; on that edge acc <= (data_i & mask_i) | (acc & ~mask_i), bit-by-bit.
REQ-016 SHALL increment count_o on each accepted beat and saturate at 255, never wrapping.
REQ-017 SHALL move ACCUM->FULL on the edge that accepts a beat with last_i=1; v_o rises the following cycle, a latency of 1 cycle.
REQ-018 SHALL drive data_o = acc in both states, registered with no combinational path from any input.
REQ-019 SHALL move FULL->ACCUM on yumi_i=1; on that edge count_o <= 0 and acc <= 0 if clear_on_start_p=1, else acc is unchanged.
REQ-020 SHALL ignore v_i, data_i, mask_i and last_i while in FULL.
REQ-021 SHALL ignore yumi_i while in ACCUM, with no state change; a simulation-only error message SHALL report this misuse.
REQ-022 SHALL treat a last beat with mask_i=0 as a completed frame; acc is unchanged and count_o increments.
REQ-023 SHALL treat a single-beat frame (first beat carries last_i) exactly as a multi-beat frame.
REQ-024 SHALL have ready_o depend on state only, never on yumi_i; a beat and a yumi never complete in the same cycle.

Reset
REQ-025 SHALL, on reset_n_i=0, asynchronously force state=ACCUM, acc=0, count_o=0, ready_o=1, v_o=0 and data_o=0.
REQ-026 SHALL discard any partial frame or unconsumed FULL word on reset; the first edge after deassertion behaves as ACCUM.

Configuration
REQ-027 SHALL, when macro BSG_MASK_MERGE_WRITTEN_MASK_EN is defined, add output written_o (width_p): OR of all accepted mask_i in the current frame, cleared at reset and on yumi_i, and valid alongside data_o.
REQ-028 SHALL, when BSG_MASK_MERGE_WRITTEN_MASK_EN is undefined, omit the written_o port and its register, with all other behaviour identical.

Verification
REQ-029 SHALL cover: width_p=64 with two beats: data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0000_0000_0000_00FF; then last data 0, mask 0x0F -> next cycle v_o=1, data_o=0x0000_0000_0000_00F0, count_o=2.
REQ-030 SHALL cover: a single last beat with mask=0 -> v_o=1, data_o=0, count_o=1; yumi_i -> ready_o=1 on the next cycle, count_o=0.
REQ-031 SHALL cover: clear_on_start_p=0, frame 1 yields 0xAA, frame 2 is last beat data 0, mask 0x0F -> data_o=0xA0.
REQ-032 SHALL cover: 300 non-last beats then a last beat -> count_o holds 255 and v_o=1 after the last beat.
REQ-033 SHALL cover: v_i held high while in FULL for 5 cycles with varied data -> data_o unchanged, count_o unchanged; yumi_i while in ACCUM -> no state change.
REQ-034 SHALL cover: reset_n_i pulsed low mid-frame after 3 beats -> outputs zero immediately and asynchronously; with BSG_MASK_MERGE_WRITTEN_MASK_EN defined, written_o=0.
